dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester data-memory arbiter (IDLE -> ACCESS -> RESP).
//            Define DMEM_ARB_RR_EN for round-robin; default is fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                any_req;
  logic                winner;
  logic                unused_addr_bits;

  assign any_req          = m0_req | m1_req;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W], m1_addr[31:ADDR_W]};

`ifdef DMEM_ARB_RR_EN
  // last_q holds the most recent winner; resetting it to 1 favours requester 0.
  logic last_q, last_d;

  assign winner = (m0_req && m1_req) ? ~last_q : m1_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && any_req && !rst) last_d = winner;
  end
`else
  assign winner = ~m0_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    case (state_q)
      IDLE: begin
        // Grant is combinational, so it must stay quiet while reset is held.
        if (any_req && !rst) begin
          m0_gnt  = ~winner;
          m1_gnt  = winner;
          owner_d = winner;
          we_d    = winner ? m1_we : m0_we;
          addr_d  = winner ? m1_addr[ADDR_W-1:0] : m0_addr[ADDR_W-1:0];
          wdata_d = winner ? m1_wdata : m0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (!we_q) begin
          if (owner_q) rdata1_d = mem_read_data;
          else         rdata0_d = mem_read_data;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_address    = {{(32-ADDR_W){1'b0}}, addr_q};
  assign mem_write_data = wdata_q;
  assign mem_write      = (state_q == ACCESS) &&  we_q;
  assign mem_read       = (state_q == ACCESS) && !we_q;
  assign m0_done        = (state_q == RESP) && !owner_q;
  assign m1_done        = (state_q == RESP) &&  owner_q;

  // Forward the memory data during the done cycle so rdata is valid alongside done.
  assign m0_rdata = (m0_done && !we_q) ? mem_read_data : rdata0_q;
  assign m1_rdata = (m1_done && !we_q) ? mem_read_data : rdata1_q;

endmodule
`default_nettype wire
